// File: rtl/multicycle_datapath_pkg.sv
// mc_pkg: shared encodings for the multicycle datapath and its control FSM.
// Holds opcodes, ALUOp / funct codes, ALUSrcB and PCSource select values,
// the internal ALU operation enum and a sign-extension helper.
package mc_pkg;

    // Opcodes seen on Op (IR[31:26])
    localparam logic [5:0] OP_LW     = 6'd0;
    localparam logic [5:0] OP_SW     = 6'd1;
    localparam logic [5:0] OP_RTYPE  = 6'd2;
    localparam logic [5:0] OP_BRANCH = 6'd3;
    localparam logic [5:0] OP_JUMP   = 6'd4;

    // ALUOp codes driven by control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALUSrcB select values
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // PCSource select values
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    // Operation actually performed by the ALU after ALU-control decode
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // 16-to-32-bit sign extension of an immediate
    function automatic logic [31:0] signExtend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: the single shared instruction/data memory port.
//   mem_addr  : address (PC or ALUOut)
//   mem_wdata : store data
//   mem_read  : read strobe
//   mem_write : write strobe
//   mem_rdata : combinational read data, valid in the same cycle as mem_addr
// master = datapath side, slave = memory side.
interface multicycle_datapath_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/multicycle_datapath_regfile.sv
// mc_regfile: NREGS x 32 register file, two asynchronous read ports and one
// synchronous write port. Register 0 is hardwired to zero.
//   clock, reset_n          : clock, asynchronous active-low reset (clears all)
//   raddr1/rdata1           : read port 1 (rs)
//   raddr2/rdata2           : read port 2 (rt)
//   we, waddr, wdata        : write port, takes effect on posedge
// A read of the register being written on the same edge returns the old value.
module mc_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [NREGS];

    // Storage: reset clears every entry; writes aimed at r0 are dropped so r0
    // stays zero even though it physically exists in the array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports are purely combinational, with r0 forced to zero.
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: datapath for the multicycle processor.
// Holds PC, register file and the IR/MDR/A/B/ALUOut holding registers, the
// ALU with its ALU-control decode, and drives the shared memory port.
//   clock, reset_n     : clock, asynchronous active-low reset
//   ALUSrcA..MemtoReg  : control inputs from the multicycle control FSM
//   Op                 : IR[31:26] back to control
//   alu_zero           : combinational ALU result == 0
//   mem                : shared memory port (master side)
module multicycle_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        ALUSrcA,
    input  logic [1:0]                  ALUSrcB,
    input  logic [1:0]                  ALUOp,
    input  logic [1:0]                  PCSource,
    input  logic                        PCWrite,
    input  logic                        PCWriteCond,
    input  logic                        IorD,
    input  logic                        MemRead,
    input  logic                        MemWrite,
    input  logic                        IRWrite,
    input  logic                        RegDst,
    input  logic                        RegWrite,
    input  logic                        MemtoReg,
    output logic [5:0]                  Op,
    output logic                        alu_zero,
    multicycle_datapath_if.master       mem
);

    logic [31:0] pc, ir, mdr, regA, regB, aluOut;
    logic [31:0] rfData1, rfData2;
    logic [31:0] aluA, aluB, aluResult, immExt, nextPc;
    logic [4:0]  rs, rt, rd, writeReg;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [25:0] target;
    logic [31:0] writeData;
    logic        pcLoad;
    alu_op_e     aluCtl;

    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm    = ir[15:0];
    assign funct  = ir[5:0];
    assign target = ir[25:0];
    assign Op     = ir[31:26];
    assign immExt = signExtend16(imm);

    assign writeReg  = RegDst ? rd : rt;
    assign writeData = MemtoReg ? mdr : aluOut;

    mc_regfile #(.NREGS(NREGS)) regfile (
        .clock  (clock),
        .reset_n(reset_n),
        .raddr1 (rs),
        .rdata1 (rfData1),
        .raddr2 (rt),
        .rdata2 (rfData2),
        .we     (RegWrite),
        .waddr  (writeReg),
        .wdata  (writeData)
    );

    // ALU operand muxes: A side picks PC or the A holding register, B side
    // picks B, the constant 4, or the sign-extended immediate (optionally
    // word-scaled for branch offsets).
    always_comb begin
        aluA = ALUSrcA ? regA : pc;
        aluB = regB;
        case (ALUSrcB)
            SRCB_B:        aluB = regB;
            SRCB_FOUR:     aluB = 32'd4;
            SRCB_IMM:      aluB = immExt;
            SRCB_IMM_SHL2: aluB = {immExt[29:0], 2'b00};
            default:       aluB = regB;
        endcase
    end

    // ALU control: ALUOp selects add/sub directly, or defers to the funct
    // field for R-type. Unknown functs fall back to add so the ALU never
    // produces an undefined result.
    always_comb begin
        aluCtl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: aluCtl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: aluCtl = ALU_ADD;
                    FUNCT_SUB: aluCtl = ALU_SUB;
                    FUNCT_AND: aluCtl = ALU_AND;
                    FUNCT_OR:  aluCtl = ALU_OR;
                    FUNCT_SLT: aluCtl = ALU_SLT;
                    default:   aluCtl = ALU_ADD;
                endcase
            end
            default: aluCtl = ALU_ADD;
        endcase
    end

    // The ALU itself; arithmetic wraps modulo 2^32 and slt is signed.
    always_comb begin
        aluResult = aluA + aluB;
        case (aluCtl)
            ALU_ADD: aluResult = aluA + aluB;
            ALU_SUB: aluResult = aluA - aluB;
            ALU_AND: aluResult = aluA & aluB;
            ALU_OR:  aluResult = aluA | aluB;
            ALU_SLT: aluResult = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
            default: aluResult = aluA + aluB;
        endcase
    end

    assign alu_zero = (aluResult == 32'd0);

    // Next-PC selection and the load condition. A taken branch reuses the
    // same zero flag the ALU is producing this cycle (A - B).
    always_comb begin
        nextPc = pc;
        case (PCSource)
            PCSRC_ALU:    nextPc = aluResult;
            PCSRC_ALUOUT: nextPc = aluOut;
            PCSRC_JUMP:   nextPc = {pc[31:28], target, 2'b00};
            PCSRC_HOLD:   nextPc = pc;
            default:      nextPc = pc;
        endcase
    end

    assign pcLoad = PCWrite | (PCWriteCond & alu_zero);

    // Architectural PC and holding registers. MDR, A, B and ALUOut reload on
    // every edge so each multicycle step sees the previous step's results;
    // only IR and PC are gated by control.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= PC_RESET;
            ir     <= '0;
            mdr    <= '0;
            regA   <= '0;
            regB   <= '0;
            aluOut <= '0;
        end else begin
            mdr    <= mem.mem_rdata;
            regA   <= rfData1;
            regB   <= rfData2;
            aluOut <= aluResult;
            if (IRWrite) begin
                ir <= mem.mem_rdata;
            end
            if (pcLoad) begin
                pc <= nextPc;
            end
        end
    end

    assign mem.mem_addr  = IorD ? aluOut : pc;
    assign mem.mem_wdata = regB;
    assign mem.mem_read  = MemRead;
    assign mem.mem_write = MemWrite;

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Datapath stage driven by the multicycle control FSM. It consumes that FSM's control signals and returns the opcode field Op to it. It holds the architectural PC and register file plus the multicycle holding registers (IR, MDR, A, B, ALUOut). It owns the ALU and ALU-control decode, and drives a single shared instruction/data memory port.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
NREGS, 32, register file depth; register 0 reads as zero

Ports:
clock  in  1  system clock, all state updates on posedge
reset_n  in  1  asynchronous active-low reset
ALUSrcA  in  1  ALU A input select: 0 = PC, 1 = A
ALUSrcB  in  2  ALU B input select: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
ALUOp  in  2  00 = add, 01 = sub, 10 = decode funct, 11 = add
PCSource  in  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = hold PC
PCWrite  in  1  unconditional PC load
PCWriteCond  in  1  PC load if ALU zero
IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  in  1  passed to mem_read
MemWrite  in  1  passed to mem_write
IRWrite  in  1  load IR from mem_rdata
RegDst  in  1  write register select: 0 = rt, 1 = rd
RegWrite  in  1  register file write enable
MemtoReg  in  1  write data select: 0 = ALUOut, 1 = MDR
Op  out  6  IR[31:26], to control
mem_addr  out  32  shared memory address
mem_wdata  out  32  store data (= B)
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_rdata  in  32  read data; combinational, valid in the same cycle as mem_addr
alu_zero  out  1  ALU result == 0, combinational

Behaviour:
- Instruction fields: Op = IR[31:26], rs = IR[25:21], rt = IR[20:16], rd = IR[15:11], imm = IR[15:0], funct = IR[5:0], target = IR[25:0].
- Reset (async, reset_n = 0): PC = PC_RESET; IR, MDR, A, B, ALUOut = 0; all registers = 0. Outputs while in reset: Op = 0, mem_addr = PC_RESET, mem_wdata = 0. mem_read/mem_write are pure pass-throughs of MemRead/MemWrite, so reset does not force them.
- Reset release mid-instruction: all datapath state restarts from the reset values. The control FSM is not reset by this block.
- Every posedge, unconditionally: MDR <= mem_rdata; A <= reg[rs]; B <= reg[rt]; ALUOut <= ALU result.
- IR <= mem_rdata only when IRWrite = 1.
- PC update: PC <= next_pc when PCWrite | (PCWriteCond & alu_zero).
- next_pc by PCSource: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], target, 2'b00}, 11 = PC.
- PCWrite and PCWriteCond both high: PC loads.
- ALU: 32-bit. Overflow and carry are discarded and wrap modulo 2^32. slt is a signed compare producing 32'd1 or 32'd0.
- ALUOp = 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; any other funct = add.
- sext(imm) is a 16-to-32-bit sign extension.
- Register file: two asynchronous read ports and one synchronous write port. Writes use the RegDst and MemtoReg selects. Writes to register 0 are ignored, and register 0 always reads 0.
- Same-edge write and read of the same register: A/B capture the old value (no bypass).
- mem_addr = IorD ? ALUOut : PC. mem_wdata = B. mem_read = MemRead, mem_write = MemWrite (combinational).
- Latency: every load into a holding register is 1 cycle. Memory reads are 0-cycle combinational, captured at the next edge.

Decomposition:
- Shared package mc_pkg holds:
  - opcodes LW = 0, SW = 1, RTYPE = 2, BRANCH = 3, JUMP = 4;
  - ALUOp codes;
  - funct codes;
  - ALUSrcB and PCSource select encodings;
  - ALU operation enum.
- One sub-module, mc_regfile: 32x32 register file with 2 read ports and 1 write port, r0 hardwired to zero, async active-low reset.
- The ALU and ALU-control decode stay inline.

Test Plan:
1. Reset: hold reset_n = 0, then release -> mem_addr = 0, Op = 0, PC = 0. Assert reset_n = 0 mid-run -> PC immediately returns to 0.
2. Fetch: mem_rdata = 32'h0822_0000 (Op = 2), IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, PCSource = 00 -> Op = 2 and PC = 4 after one edge.
3. R-type: r1 = 7, r2 = 5, funct 0x22, ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUOut = 2. RegDst = 1, RegWrite = 1, MemtoReg = 0 -> rd = 2. Repeat with funct 0x2A -> rd = 0.
4. Load/store: A = 0x100, imm = 0xFFFC, ALUSrcB = 10 -> ALUOut = 0xFC. IorD = 1 -> mem_addr = 0xFC. Store cycle: mem_wdata = B, mem_write = 1. Load: MDR captured, MemtoReg = 1 writes rt.
5. Branch/jump: A == B, PCWriteCond = 1, PCSource = 01, ALUOut = 0x40 -> PC = 0x40. With A != B -> PC unchanged. Jump with target 0x10, PCSource = 10 -> PC = {PC[31:28], 0x40}.
6. Register 0 and hazards: write 0x55 to r0 -> reads 0. Write r3 while rs = 3 on the same edge -> A = old value, new value visible one cycle later.
